// File: rtl/if_stage_if.sv
// Instruction-memory read bus between the fetch stage (master) and the memory (slave).
interface if_stage_if;
  logic        Imem_req;
  logic [31:0] Imem_addr;
  logic        Imem_valid;
  logic [31:0] Imem_rdata;

  modport master (
    output Imem_req,
    output Imem_addr,
    input  Imem_valid,
    input  Imem_rdata
  );

  modport slave (
    input  Imem_req,
    input  Imem_addr,
    output Imem_valid,
    output Imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: REQ/WAIT/ISSUE sequencer with PC+4, branch and jump next-PC select.
// Define IF_TIMEOUT_EN to enable the instruction-memory wait timeout and the sticky Fetch_err flag.
module if_stage #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input  logic               Clk,
  input  logic               Clrn,
  input  logic [1:0]         Pcsrc,
  input  logic signed [31:0] Branch_off,
  input  logic [25:0]        J_target,
  input  logic               Stall,
  if_stage_if.master         imem,
  output logic [31:0]        Inst,
  output logic [5:0]         Op,
  output logic [5:0]         Func,
  output logic               Inst_valid,
  output logic [31:0]        Pc,
  output logic [31:0]        Pc4,
  output logic               Fetch_err
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_ISSUE} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        inst_q, inst_d;
  logic [31:0]        pc4_w;
  logic [31:0]        next_pc_w;
  logic signed [31:0] br_off_w;
  logic               timeout_w;

  assign pc4_w    = pc_q + 32'd4;
  assign br_off_w = Branch_off <<< 2;

  always_comb begin
    case (Pcsrc)
      2'b01:   next_pc_w = pc4_w + $unsigned(br_off_w);
      2'b10:   next_pc_w = {pc4_w[31:28], J_target, 2'b00};
      default: next_pc_w = pc4_w;
    endcase
  end

`ifdef IF_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q;

  assign timeout_w = (state_q == S_WAIT) && !imem.Imem_valid &&
                     (cnt_q == TIMEOUT_CYCLES - 8'd1);

  // Counter only runs while waiting; any exit from WAIT clears it.
  always_comb begin
    cnt_d = '0;
    if ((state_q == S_WAIT) && !imem.Imem_valid && !timeout_w) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_q | timeout_w;
    end
  end

  assign Fetch_err = err_q;
`else
  assign timeout_w = 1'b0;
  assign Fetch_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      S_REQ: begin
        // A response in the request cycle itself is accepted directly.
        if (imem.Imem_valid) begin
          inst_d  = imem.Imem_rdata;
          state_d = S_ISSUE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.Imem_valid) begin
          inst_d  = imem.Imem_rdata;
          state_d = S_ISSUE;
        end else if (timeout_w) begin
          state_d = S_REQ;
        end
      end
      S_ISSUE: begin
        if (!Stall) begin
          pc_d    = next_pc_w;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign imem.Imem_req  = (state_q == S_REQ);
  assign imem.Imem_addr = pc_q;
  assign Inst           = inst_q;
  assign Op             = inst_q[31:26];
  assign Func           = inst_q[5:0];
  assign Inst_valid     = (state_q == S_ISSUE);
  assign Pc             = pc_q;
  assign Pc4            = pc4_w;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by randomized fetch traffic
// compared against a transaction-level reference model.
module tb_if_stage;

  logic        Clk = 1'b0;
  logic        Clrn;
  logic [1:0]  Pcsrc;
  logic [31:0] Branch_off;
  logic [25:0] J_target;
  logic        Stall;
  logic [31:0] Inst;
  logic [5:0]  Op;
  logic [5:0]  Func;
  logic        Inst_valid;
  logic [31:0] Pc;
  logic [31:0] Pc4;
  logic        Fetch_err;

  int n_chk = 0;
  int n_err = 0;

  if_stage_if imem_bus ();

  if_stage dut (
    .Clk        (Clk),
    .Clrn       (Clrn),
    .Pcsrc      (Pcsrc),
    .Branch_off (Branch_off),
    .J_target   (J_target),
    .Stall      (Stall),
    .imem       (imem_bus),
    .Inst       (Inst),
    .Op         (Op),
    .Func       (Func),
    .Inst_valid (Inst_valid),
    .Pc         (Pc),
    .Pc4        (Pc4),
    .Fetch_err  (Fetch_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference next-PC rule from plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [1:0] sel,
                                             input logic [31:0] boff, input logic [25:0] jt);
    logic [31:0] seq;
    logic [31:0] jt32;
    seq  = pc + 32'd4;
    jt32 = {6'd0, jt};
    case (sel)
      2'b01:   return seq + boff * 32'd4;
      2'b10:   return (seq & 32'hF000_0000) | (jt32 * 32'd4);
      default: return seq;
    endcase
  endfunction

  // Called in a REQ cycle: answer after lat cycles, then check the issued instruction.
  task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input int lat);
    chk({tag, "_req"}, 32'(imem_bus.Imem_req), 32'd1);
    chk({tag, "_addr"}, imem_bus.Imem_addr, addr);
    for (int i = 0; i < lat; i++) begin
      imem_bus.Imem_valid = 1'b0;
      tick();
      chk({tag, "_waitreq"}, 32'(imem_bus.Imem_req), 32'd0);
      chk({tag, "_waitvld"}, 32'(Inst_valid), 32'd0);
    end
    imem_bus.Imem_valid = 1'b1;
    imem_bus.Imem_rdata = data;
    tick();
    imem_bus.Imem_valid = 1'b0;
    imem_bus.Imem_rdata = $urandom;
    chk({tag, "_ivld"}, 32'(Inst_valid), 32'd1);
    chk({tag, "_inst"}, Inst, data);
    chk({tag, "_pc"}, Pc, addr);
    chk({tag, "_pc4"}, Pc4, addr + 32'd4);
  endtask

  // Called in an ISSUE cycle: release with the given selection and check the next request.
  task automatic issue(input string tag, input logic [1:0] sel, input logic [31:0] boff,
                       input logic [25:0] jt, input logic [31:0] exp_addr);
    Pcsrc      = sel;
    Branch_off = boff;
    J_target   = jt;
    Stall      = 1'b0;
    tick();
    Pcsrc      = $urandom;
    Branch_off = $urandom;
    J_target   = $urandom;
    chk({tag, "_nreq"}, 32'(imem_bus.Imem_req), 32'd1);
    chk({tag, "_naddr"}, imem_bus.Imem_addr, exp_addr);
  endtask

  logic [31:0] exp_pc;
  logic [31:0] exp_inst;
  int          phase;
  int          lat;
  int          gap;
  bit          seen;

  initial begin
    Clrn                = 1'b0;
    Pcsrc               = 2'b00;
    Branch_off          = '0;
    J_target            = '0;
    Stall               = 1'b0;
    imem_bus.Imem_valid = 1'b0;
    imem_bus.Imem_rdata = '0;
    tick();
    tick();
    chk("rst_pc", Pc, 32'h0);
    chk("rst_inst", Inst, 32'h0);
    chk("rst_ivld", 32'(Inst_valid), 32'd0);
    chk("rst_err", 32'(Fetch_err), 32'd0);
    Clrn = 1'b1;

    do_fetch("f0", 32'h0, 32'h0000_0820, 1);
    chk("f0_op", 32'(Op), 32'h0);
    chk("f0_func", 32'(Func), 32'h20);

    issue("j40", 2'b10, 32'h0, 26'h10, 32'h40);
    do_fetch("f40", 32'h40, 32'h1111_2222, 0);
    issue("br", 2'b01, 32'hFFFF_FFFE, 26'h0, 32'h3C);
    do_fetch("f3c", 32'h3C, 32'h8C22_0004, 2);
    chk("f3c_op", 32'(Op), 32'h23);
    issue("brbig", 2'b01, 32'h03FF_FFF0, 26'h0, 32'h1000_0000);
    do_fetch("f1k", 32'h1000_0000, 32'h0800_0040, 0);
    issue("jhi", 2'b10, 32'h0, 26'h000_0040, 32'h1000_0100);
    do_fetch("f1k1", 32'h1000_0100, 32'hABCD_0123, 1);

    // Stall holds the issued instruction; ignored bus activity must not disturb it.
    for (int i = 0; i < 3; i++) begin
      Stall               = 1'b1;
      Pcsrc               = 2'b10;
      imem_bus.Imem_valid = 1'b1;
      imem_bus.Imem_rdata = 32'hDEAD_BEEF;
      tick();
      chk("stl_ivld", 32'(Inst_valid), 32'd1);
      chk("stl_inst", Inst, 32'hABCD_0123);
      chk("stl_pc", Pc, 32'h1000_0100);
      chk("stl_req", 32'(imem_bus.Imem_req), 32'd0);
    end
    imem_bus.Imem_valid = 1'b0;
    issue("unstl", 2'b00, 32'h0, 26'h0, 32'h1000_0104);
    do_fetch("f104", 32'h1000_0104, 32'h0000_0001, 0);

    issue("towrap", 2'b01, 32'h3BFF_FFBD, 26'h0, 32'hFFFF_FFFC);
    do_fetch("ffc", 32'hFFFF_FFFC, 32'h0000_0002, 0);
    chk("wrap_pc4", Pc4, 32'h0);
    issue("sel11", 2'b11, 32'h1234_5678, 26'h3FF_FFFF, 32'h0);
    do_fetch("f0b", 32'h0, 32'h0000_0003, 0);

    issue("j80", 2'b10, 32'h0, 26'h20, 32'h80);
    imem_bus.Imem_valid = 1'b0;
    tick();
    chk("w80_req", 32'(imem_bus.Imem_req), 32'd0);
    Clrn                = 1'b0;
    imem_bus.Imem_valid = 1'b1;
    imem_bus.Imem_rdata = 32'h5555_5555;
    tick();
    Clrn                = 1'b1;
    imem_bus.Imem_valid = 1'b0;
    chk("rw_ivld", 32'(Inst_valid), 32'd0);
    chk("rw_inst", Inst, 32'h0);
    do_fetch("rw", 32'h0, 32'h0000_CAFE, 0);

    // Withheld response.
    issue("to", 2'b00, 32'h0, 26'h0, 32'h4);
    imem_bus.Imem_valid = 1'b0;
    gap  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (imem_bus.Imem_req) begin
        gap  = i;
        seen = 1'b1;
        break;
      end
    end
`ifdef IF_TIMEOUT_EN
    chk("to_seen", 32'(seen), 32'd1);
    chk("to_gap", 32'(gap), 32'd256);
    chk("to_err", 32'(Fetch_err), 32'd1);
    do_fetch("to_re", 32'h4, 32'h0000_0777, 0);
    chk("to_sticky", 32'(Fetch_err), 32'd1);
`else
    chk("nto_seen", 32'(seen), 32'd0);
    chk("nto_err", 32'(Fetch_err), 32'd0);
    chk("nto_ivld", 32'(Inst_valid), 32'd0);
    imem_bus.Imem_valid = 1'b1;
    imem_bus.Imem_rdata = 32'h0000_0777;
    tick();
    imem_bus.Imem_valid = 1'b0;
    chk("nto_inst", Inst, 32'h0000_0777);
    chk("nto_pc", Pc, 32'h4);
`endif

    // Random traffic against the transaction-level model; phase 0=REQ, 1=WAIT, 2=ISSUE.
    exp_pc   = 32'h4;
    exp_inst = 32'h0000_0777;
    phase    = 2;
    lat      = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      chk("r_req", 32'(imem_bus.Imem_req), 32'(phase == 0));
      chk("r_ivld", 32'(Inst_valid), 32'(phase == 2));
      chk("r_pc", Pc, exp_pc);
      if (phase == 0) chk("r_addr", imem_bus.Imem_addr, exp_pc);
      if (phase == 2) begin
        chk("r_inst", Inst, exp_inst);
        chk("r_op", 32'(Op), 32'(exp_inst[31:26]));
        chk("r_func", 32'(Func), 32'(exp_inst[5:0]));
        chk("r_pc4", Pc4, exp_pc + 32'd4);
      end
      imem_bus.Imem_valid = 1'b0;
      imem_bus.Imem_rdata = $urandom;
      Stall               = 1'b0;
      Pcsrc               = 2'($urandom);
      Branch_off          = $urandom;
      J_target            = 26'($urandom);
      case (phase)
        0: begin
          lat = $urandom_range(0, 3);
          if (lat == 0) begin
            imem_bus.Imem_valid = 1'b1;
            exp_inst            = imem_bus.Imem_rdata;
            phase               = 2;
          end else begin
            phase = 1;
          end
        end
        1: begin
          lat--;
          if (lat == 0) begin
            imem_bus.Imem_valid = 1'b1;
            exp_inst            = imem_bus.Imem_rdata;
            phase               = 2;
          end
        end
        default: begin
          if ($urandom_range(0, 3) == 0) imem_bus.Imem_valid = 1'b1;
          Stall = ($urandom_range(0, 2) == 0);
          if (!Stall) begin
            exp_pc = model_next(exp_pc, Pcsrc, Branch_off, J_target);
            phase  = 0;
          end
        end
      endcase
      tick();
    end
    chk("r_err", 32'(Fetch_err), 32'd0 | 32'(Fetch_err && 1'b0)
`ifdef IF_TIMEOUT_EN
        | 32'd1
`endif
    );

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
